ctrl_dispatch_fsm: RTL and testbench

CTRL_DISPATCH_FSM -- requirements
Module: ctrl_dispatch_fsm

---
 rtl/ctrl_dispatch_fsm.sv | 234 +++++++++++++++++++++++
 tb/tb_ctrl_dispatch_fsm.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_dispatch_fsm.sv
// ctrl_dispatch_fsm: accepts one host command at a time, starts the matching
// GET/PUT/DEL sub-FSM, muxes that sub-FSM's memory commands to the shared
// memory block, bounds its run time with a saturating timeout counter and
// returns a single status response with a valid/ready handshake.
module ctrl_dispatch_fsm #(
    parameter int NUM_ENTRIES    = 16,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,

    // Host command / response
    input  logic                   cmd_valid,
    input  logic [1:0]             cmd_op,
    output logic                   cmd_ready,
    output logic                   resp_valid,
    output logic [1:0]             resp_status,
    input  logic                   resp_ready,
    output logic                   busy,

    // Sub-FSM control
    output logic                   get_en,
    output logic                   put_en,
    output logic                   del_en,
    output logic                   get_enter,
    output logic                   put_enter,
    output logic                   del_enter,
    input  logic                   get_done,
    input  logic                   put_done,
    input  logic                   del_done,
    input  logic                   get_error,
    input  logic                   put_error,
    input  logic                   del_error,

    // Sub-FSM memory commands
    input  logic                   get_select,
    input  logic                   get_write,
    input  logic                   get_delete,
    input  logic [NUM_ENTRIES-1:0] get_idx,
    input  logic                   put_select,
    input  logic                   put_write,
    input  logic                   put_delete,
    input  logic [NUM_ENTRIES-1:0] put_idx,
    input  logic                   del_select,
    input  logic                   del_write,
    input  logic                   del_delete,
    input  logic [NUM_ENTRIES-1:0] del_idx,

    // Muxed memory commands
    output logic                   mem_select,
    output logic                   mem_write,
    output logic                   mem_delete,
    output logic [NUM_ENTRIES-1:0] mem_idx
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ENTER = 2'd1,
        S_RUN   = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    localparam logic [1:0] OP_NOP = 2'b00;
    localparam logic [1:0] OP_GET = 2'b01;
    localparam logic [1:0] OP_PUT = 2'b10;
    localparam logic [1:0] OP_DEL = 2'b11;

    localparam logic [1:0] ST_OK      = 2'b00;
    localparam logic [1:0] ST_ERROR   = 2'b01;
    localparam logic [1:0] ST_TIMEOUT = 2'b10;
    localparam logic [1:0] ST_ILLEGAL = 2'b11;

    // Counter value seen in the last permitted RUN cycle.
    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [15:0] CNT_MAX  = 16'hFFFF;

    state_t      state_q, state_d;
    logic [1:0]  op_q, op_d;
    logic [15:0] cnt_q, cnt_d;
    logic [1:0]  status_q, status_d;

    logic        sel_done;
    logic        sel_error;

    // State and datapath registers, cleared asynchronously by rst_n.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            op_q     <= OP_NOP;
            cnt_q    <= 16'd0;
            status_q <= ST_OK;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            status_q <= status_d;
        end
    end

    // Next-state logic: only the latched op's done/error is ever observed.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        cnt_d     = cnt_q;
        status_d  = status_q;
        sel_done  = 1'b0;
        sel_error = 1'b0;

        case (op_q)
            OP_GET: begin
                sel_done  = get_done;
                sel_error = get_error;
            end
            OP_PUT: begin
                sel_done  = put_done;
                sel_error = put_error;
            end
            OP_DEL: begin
                sel_done  = del_done;
                sel_error = del_error;
            end
            default: begin
                sel_done  = 1'b0;
                sel_error = 1'b0;
            end
        endcase

        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    op_d = cmd_op;
                    if (cmd_op == OP_NOP) begin
                        status_d = ST_ILLEGAL;
                        state_d  = S_RESP;
                    end else begin
                        state_d  = S_ENTER;
                    end
                end
            end
            S_ENTER: begin
                cnt_d   = 16'd0;
                state_d = S_RUN;
            end
            S_RUN: begin
                if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + 16'd1;
                end
                // Sub-FSM status beats the timeout; error beats done.
                if (sel_error) begin
                    status_d = ST_ERROR;
                    state_d  = S_RESP;
                end else if (sel_done) begin
                    status_d = ST_OK;
                    state_d  = S_RESP;
                end else if (cnt_q == CNT_LAST) begin
                    status_d = ST_TIMEOUT;
                    state_d  = S_RESP;
                end
            end
            S_RESP: begin
                if (resp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output decode: handshakes, one-hot sub-FSM enables and the memory mux.
    always_comb begin
        cmd_ready   = 1'b0;
        resp_valid  = 1'b0;
        resp_status = 2'b00;
        busy        = 1'b1;
        get_en      = 1'b0;
        put_en      = 1'b0;
        del_en      = 1'b0;
        get_enter   = 1'b0;
        put_enter   = 1'b0;
        del_enter   = 1'b0;
        mem_select  = 1'b0;
        mem_write   = 1'b0;
        mem_delete  = 1'b0;
        mem_idx     = '0;

        case (state_q)
            S_IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
            end
            S_ENTER, S_RUN: begin
                case (op_q)
                    OP_GET: begin
                        get_en     = 1'b1;
                        get_enter  = (state_q == S_ENTER);
                        mem_select = get_select;
                        mem_write  = get_write;
                        mem_delete = get_delete;
                        mem_idx    = get_idx;
                    end
                    OP_PUT: begin
                        put_en     = 1'b1;
                        put_enter  = (state_q == S_ENTER);
                        mem_select = put_select;
                        mem_write  = put_write;
                        mem_delete = put_delete;
                        mem_idx    = put_idx;
                    end
                    OP_DEL: begin
                        del_en     = 1'b1;
                        del_enter  = (state_q == S_ENTER);
                        mem_select = del_select;
                        mem_write  = del_write;
                        mem_delete = del_delete;
                        mem_idx    = del_idx;
                    end
                    default: begin
                        get_en = 1'b0;
                    end
                endcase
            end
            S_RESP: begin
                resp_valid  = 1'b1;
                resp_status = status_q;
            end
            default: begin
                busy = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_ctrl_dispatch_fsm.sv
// Self-checking bench for ctrl_dispatch_fsm: directed scenarios plus
// randomized transactions checked cycle by cycle against a transaction-level
// reference model of the dispatcher.
module tb_ctrl_dispatch_fsm;

    localparam int NE = 16;
    localparam int T  = 4;

    localparam int PH_IDLE  = 0;
    localparam int PH_ENTER = 1;
    localparam int PH_RUN   = 2;
    localparam int PH_RESP  = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic cmd_valid = 1'b0;
    logic [1:0] cmd_op = 2'b00;
    logic resp_ready = 1'b0;
    logic cmd_ready, resp_valid, busy;
    logic [1:0] resp_status;
    logic get_en, put_en, del_en, get_enter, put_enter, del_enter;
    logic get_done = 0, put_done = 0, del_done = 0;
    logic get_error = 0, put_error = 0, del_error = 0;
    logic get_select = 0, get_write = 0, get_delete = 0;
    logic put_select = 0, put_write = 0, put_delete = 0;
    logic del_select = 0, del_write = 0, del_delete = 0;
    logic [NE-1:0] get_idx = '0, put_idx = '0, del_idx = '0;
    logic mem_select, mem_write, mem_delete;
    logic [NE-1:0] mem_idx;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    ctrl_dispatch_fsm #(.NUM_ENTRIES(NE), .TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_ready(cmd_ready),
        .resp_valid(resp_valid), .resp_status(resp_status), .resp_ready(resp_ready),
        .busy(busy),
        .get_en(get_en), .put_en(put_en), .del_en(del_en),
        .get_enter(get_enter), .put_enter(put_enter), .del_enter(del_enter),
        .get_done(get_done), .put_done(put_done), .del_done(del_done),
        .get_error(get_error), .put_error(put_error), .del_error(del_error),
        .get_select(get_select), .get_write(get_write), .get_delete(get_delete), .get_idx(get_idx),
        .put_select(put_select), .put_write(put_write), .put_delete(put_delete), .put_idx(put_idx),
        .del_select(del_select), .del_write(del_write), .del_delete(del_delete), .del_idx(del_idx),
        .mem_select(mem_select), .mem_write(mem_write), .mem_delete(mem_delete), .mem_idx(mem_idx)
    );

    // Observed output bundle: ready, valid, status, busy, en[3], enter[3], mem s/w/d, idx.
    wire [13+NE:0] obs = {cmd_ready, resp_valid, resp_status, busy,
                          get_en, put_en, del_en, get_enter, put_enter, del_enter,
                          mem_select, mem_write, mem_delete, mem_idx};

    // Reference: what the dispatcher must present in a given phase of a transaction.
    function automatic logic [13+NE:0] model(input int ph, input logic [1:0] op, input logic [1:0] st);
        logic [2:0] oh;
        logic [2+NE:0] mem;
        oh  = (op == 2'd1) ? 3'b100 : (op == 2'd2) ? 3'b010 : (op == 2'd3) ? 3'b001 : 3'b000;
        mem = (op == 2'd1) ? {get_select, get_write, get_delete, get_idx} :
              (op == 2'd2) ? {put_select, put_write, put_delete, put_idx} :
              (op == 2'd3) ? {del_select, del_write, del_delete, del_idx} : '0;
        case (ph)
            PH_IDLE:  model = {1'b1, 1'b0, 2'b00, 1'b0, 3'b000, 3'b000, {(3+NE){1'b0}}};
            PH_ENTER: model = {1'b0, 1'b0, 2'b00, 1'b1, oh, oh, mem};
            PH_RUN:   model = {1'b0, 1'b0, 2'b00, 1'b1, oh, 3'b000, mem};
            default:  model = {1'b0, 1'b1, st, 1'b1, 3'b000, 3'b000, {(3+NE){1'b0}}};
        endcase
    endfunction

    // Random sub-FSM activity; the selected op's done/error are forced to d/e.
    task automatic drive_sub(input logic [1:0] op, input logic d, input logic e);
        {get_done, put_done, del_done}    = 3'($urandom);
        {get_error, put_error, del_error} = 3'($urandom);
        {get_select, get_write, get_delete} = 3'($urandom);
        {put_select, put_write, put_delete} = 3'($urandom);
        {del_select, del_write, del_delete} = 3'($urandom);
        get_idx = NE'($urandom);
        put_idx = NE'($urandom);
        del_idx = NE'($urandom);
        case (op)
            2'd1: begin get_done = d; get_error = e; end
            2'd2: begin put_done = d; put_error = e; end
            2'd3: begin del_done = d; del_error = e; end
            default: ;
        endcase
    endtask

    // One full command; entered and left at posedge+1 with the DUT in IDLE.
    // resp_k: RUN cycle in which the sub-FSM reports (negative = never).
    task automatic do_txn(input string nm, input logic [1:0] op, input int resp_k,
                          input bit use_err, input bit use_done, input int bp, input bit fixed_mux);
        bit respond;
        int n_run;
        logic [1:0] st;
        logic [13+NE:0] exp_v;
        respond = (use_err || use_done) && resp_k >= 0 && resp_k <= T - 1;
        n_run   = respond ? resp_k + 1 : T;
        st      = (op == 2'd0) ? 2'b11 : !respond ? 2'b10 : use_err ? 2'b01 : 2'b00;

        // Accept cycle
        drive_sub(2'd0, 1'b0, 1'b0);
        cmd_valid = 1'b1; cmd_op = op; resp_ready = 1'($urandom);
        @(negedge clk);
        exp_v = model(PH_IDLE, op, st);
        n_cmp++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s accept: got %h expected %h", nm, obs, exp_v);
        end
        @(posedge clk); #1;

        if (op != 2'd0) begin
            // Enter cycle
            cmd_valid = 1'($urandom); cmd_op = 2'($urandom); resp_ready = 1'($urandom);
            drive_sub(op, 1'b0, 1'b0);
            @(negedge clk);
            exp_v = model(PH_ENTER, op, st);
            n_cmp++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL %s enter: got %h expected %h", nm, obs, exp_v);
            end
            @(posedge clk); #1;
            // Run cycles
            for (int k = 0; k < n_run; k++) begin
                cmd_valid = 1'($urandom); cmd_op = 2'($urandom); resp_ready = 1'($urandom);
                if (k == resp_k) drive_sub(op, 1'(use_done), 1'(use_err));
                else             drive_sub(op, 1'b0, 1'b0);
                if (fixed_mux) begin
                    del_idx = 16'h0010; del_delete = 1'b1;
                    get_done = (k == 1); get_error = 1'b0;
                end
                @(negedge clk);
                exp_v = model(PH_RUN, op, st);
                n_cmp++;
                if (obs !== exp_v) begin
                    n_fail++;
                    $display("FAIL %s run%0d: got %h expected %h", nm, k, obs, exp_v);
                end
                @(posedge clk); #1;
            end
        end

        // Response, with bp cycles of backpressure
        for (int b = 0; b <= bp; b++) begin
            cmd_valid = 1'($urandom); cmd_op = 2'($urandom);
            resp_ready = (b == bp);
            drive_sub(op, 1'($urandom), 1'($urandom));
            @(negedge clk);
            exp_v = model(PH_RESP, op, st);
            n_cmp++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL %s resp%0d: got %h expected %h", nm, b, obs, exp_v);
            end
            @(posedge clk); #1;
        end
        cmd_valid = 1'b0; resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        logic [13+NE:0] exp_v;
        rst_n = 1'b0;
        drive_sub(2'd0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        exp_v = model(PH_IDLE, 2'd0, 2'd0);
        n_cmp++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL reset_held: got %h expected %h", obs, exp_v);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL reset_release: got %h expected %h", obs, exp_v);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_del();
        do_txn("del_done", 2'd3, 2, 1'b0, 1'b1, 0, 1'b0);
    endtask

    task automatic test_get_miss();
        do_txn("get_miss", 2'd1, 1, 1'b1, 1'b1, 1, 1'b0);
    endtask

    task automatic test_timeout();
        do_txn("put_timeout", 2'd2, -1, 1'b0, 1'b0, 0, 1'b0);
        do_txn("late_done", 2'd1, T, 1'b0, 1'b1, 0, 1'b0);
        do_txn("done_at_limit", 2'd3, T - 1, 1'b0, 1'b1, 0, 1'b0);
        do_txn("err_at_limit", 2'd2, T - 1, 1'b1, 1'b0, 0, 1'b0);
    endtask

    task automatic test_illegal();
        do_txn("illegal", 2'd0, -1, 1'b0, 1'b0, 0, 1'b0);
        do_txn("illegal_bp", 2'd0, -1, 1'b0, 1'b0, 3, 1'b0);
    endtask

    task automatic test_backpressure_mux();
        do_txn("bp_mux", 2'd3, 2, 1'b0, 1'b1, 5, 1'b1);
    endtask

    task automatic test_reset_mid_run();
        logic [13+NE:0] exp_v;
        cmd_valid = 1'b1; cmd_op = 2'd2;
        drive_sub(2'd0, 1'b0, 1'b0);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            drive_sub(2'd2, 1'b0, 1'b0);
            @(posedge clk); #1;
        end
        // Mid-RUN: busy with put_en high before reset
        n_cmp++;
        if ({busy, put_en} !== 2'b11) begin
            n_fail++;
            $display("FAIL mid_run_busy: got %b expected 11", {busy, put_en});
        end
        #2 rst_n = 1'b0;
        #1;
        exp_v = model(PH_IDLE, 2'd0, 2'd0);
        n_cmp++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL async_reset: got %h expected %h", obs, exp_v);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        do_txn("get_after_reset", 2'd1, 1, 1'b0, 1'b1, 0, 1'b0);
    endtask

    task automatic test_back_to_back();
        do_txn("b2b_a", 2'd1, 0, 1'b0, 1'b1, 0, 1'b0);
        do_txn("b2b_b", 2'd2, 0, 1'b1, 1'b0, 0, 1'b0);
        do_txn("b2b_c", 2'd0, -1, 1'b0, 1'b0, 0, 1'b0);
        do_txn("b2b_d", 2'd3, 1, 1'b1, 1'b1, 0, 1'b0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            do_txn("random", 2'($urandom), $urandom_range(0, T + 2),
                   1'($urandom), 1'($urandom), $urandom_range(0, 3), 1'b0);
        end
    endtask

    task automatic test_final_idle();
        logic [13+NE:0] exp_v;
        drive_sub(2'd0, 1'b0, 1'b0);
        @(negedge clk);
        exp_v = model(PH_IDLE, 2'd0, 2'd0);
        n_cmp++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL final_idle: got %h expected %h", obs, exp_v);
        end
    endtask

    initial begin
        test_reset();
        test_del();
        test_get_miss();
        test_timeout();
        test_illegal();
        test_backpressure_mux();
        test_reset_mid_run();
        test_back_to_back();
        test_random();
        test_final_idle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
